// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 write-back register file with a retired-write counter.
// Define WB_BYPASS_EN for same-cycle write-through on both read ports.
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [31:0]      ALUResult_i,
  input  logic [31:0]      MemData_i,
  input  logic [4:0]       RegDest_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  output logic [31:0]      RS1data_o,
  output logic [31:0]      RS2data_o,
  output logic [31:0]      WBData_o,
  output logic [CNT_W-1:0] WrCount_o
);

  logic [31:0]      regs [1:31];
  logic [CNT_W-1:0] wrCnt;
  logic             wrEn;
  logic [31:0]      rs1Data;
  logic [31:0]      rs2Data;

  assign WBData_o = MemtoReg_i ? MemData_i : ALUResult_i;
  assign wrEn     = RegWrite_i && (RegDest_i != 5'd0);

  // x0 has no storage; it is hardwired to zero on the read side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
      wrCnt <= '0;
    end else if (wrEn) begin
      regs[RegDest_i] <= WBData_o;
      wrCnt           <= wrCnt + 1'b1;
    end
  end

  always_comb begin
    rs1Data = '0;
    if (RS1addr_i != 5'd0) begin
      rs1Data = regs[RS1addr_i];
`ifdef WB_BYPASS_EN
      if (rst_n && wrEn && (RS1addr_i == RegDest_i)) begin
        rs1Data = WBData_o;
      end
`endif
    end
  end

  always_comb begin
    rs2Data = '0;
    if (RS2addr_i != 5'd0) begin
      rs2Data = regs[RS2addr_i];
`ifdef WB_BYPASS_EN
      if (rst_n && wrEn && (RS2addr_i == RegDest_i)) begin
        rs2Data = WBData_o;
      end
`endif
    end
  end

  assign RS1data_o = rs1Data;
  assign RS2data_o = rs2Data;
  assign WrCount_o = wrCnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile against
// an array-based reference model of the register file.
module tb_wb_regfile;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          regWrite;
  logic          memToReg;
  logic [31:0]   aluRes;
  logic [31:0]   memData;
  logic [4:0]    dest;
  logic [4:0]    a1;
  logic [4:0]    a2;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  logic [31:0]   wb;
  logic [CW-1:0] wrCount;

  logic [31:0]   mdl [32];
  int unsigned   cnt;
  int            vectors = 0;
  int            miscompares = 0;

  wb_regfile #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite_i  (regWrite),
    .MemtoReg_i  (memToReg),
    .ALUResult_i (aluRes),
    .MemData_i   (memData),
    .RegDest_i   (dest),
    .RS1addr_i   (a1),
    .RS2addr_i   (a2),
    .RS1data_o   (rs1),
    .RS2data_o   (rs2),
    .WBData_o    (wb),
    .WrCount_o   (wrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expWb();
    return memToReg ? memData : aluRes;
  endfunction

  function automatic logic [31:0] expRd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (regWrite && dest != 5'd0 && a == dest) return expWb();
`endif
    return mdl[a];
  endfunction

  function automatic logic [31:0] cntNow();
    return {{(32-CW){1'b0}}, wrCount};
  endfunction

  function automatic logic [31:0] cntExp();
    return cnt % (1 << CW);
  endfunction

  // one cycle: apply at negedge, check comb outputs, clock, check state
  task automatic step(input logic rw, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] d, input logic [4:0] r1,
                      input logic [4:0] r2);
    logic [31:0] w;
    @(negedge clk);
    regWrite = rw;
    memToReg = m2r;
    aluRes   = alu;
    memData  = mem;
    dest     = d;
    a1       = r1;
    a2       = r2;
    #1;
    w = expWb();
    chk("wbdata", wb, w);
    chk("rs1", rs1, expRd(r1));
    chk("rs2", rs2, expRd(r2));
    @(posedge clk);
    if (rst_n && rw && d != 5'd0) begin
      mdl[d] = w;
      cnt++;
    end
    #1;
    chk("count", cntNow(), cntExp());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    regWrite = 1'b1;
    dest     = 5'd9;
    aluRes   = 32'h0BAD_0BAD;
    memToReg = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    cnt = 0;
    a1  = 5'd9;
    a2  = 5'd5;
    #1;
    chk("rst_rs1", rs1, 32'h0);
    chk("rst_rs2", rs2, 32'h0);
    chk("rst_cnt", cntNow(), 32'h0);
    chk("rst_wb", wb, 32'h0BAD_0BAD);
    @(posedge clk);
    #1;
    chk("rst_hold_rs1", rs1, 32'h0);
    chk("rst_hold_cnt", cntNow(), 32'h0);
    @(negedge clk);
    regWrite = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    logic [31:0] hz;
    rst_n    = 1'b1;
    regWrite = 1'b0;
    memToReg = 1'b0;
    aluRes   = '0;
    memData  = '0;
    dest     = '0;
    a1       = '0;
    a2       = '0;
    cnt      = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    doReset();

    step(1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 5'd0, 5'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("x5_read", rs1, 32'h1234_5678);
    chk("cnt_one", cntNow(), 32'h1);

    step(1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd7, 5'd0, 5'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    chk("x7_mem", rs1, 32'hDEAD_BEEF);
    chk("x7_same", rs2, 32'hDEAD_BEEF);

    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("x0_zero", rs2, 32'h0);
    chk("x0_cnt", cntNow(), 32'h2);

`ifdef WB_BYPASS_EN
    hz = 32'hA5A5_A5A5;
`else
    hz = 32'h0;
`endif
    @(negedge clk);
    regWrite = 1'b1;
    memToReg = 1'b0;
    aluRes   = 32'hA5A5_A5A5;
    dest     = 5'd3;
    a1       = 5'd3;
    a2       = 5'd0;
    #1;
    chk("hazard", rs1, hz);
    @(posedge clk);
    mdl[3] = 32'hA5A5_A5A5;
    cnt++;
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    chk("x3_after", rs1, 32'hA5A5_A5A5);

    step(1'b0, 1'b1, 32'h7, 32'h8, 5'd3, 5'd3, 5'd7);
    chk("nowrite_cnt", cntNow(), 32'h3);

    for (int n = 0; n < 300; n++) begin
      logic [4:0] d;
      logic [4:0] r1;
      logic [4:0] r2;
      d  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           $urandom, $urandom, d, r1, r2);
    end

    doReset();
    for (int n = 0; n < 17; n++) begin
      step(1'b1, 1'b0, $urandom, 32'h0, 5'($urandom_range(1, 31)),
           5'd0, 5'd0);
    end
    chk("wrap17", cntNow(), 32'h1);

    step(1'b1, 1'b0, 32'h55, 32'h0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    chk("x9_pre", rs1, 32'h55);
    doReset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    chk("x9_cleared", rs1, 32'h0);
    step(1'b1, 1'b0, 32'h66, 32'h0, 5'd9, 5'd0, 5'd0);
    chk("first_after", cntNow(), 32'h1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The parameter list SHALL be: CNT_W, default 16, width of the write-retire counter.
REQ-002 The ports SHALL be: clk  input  1  rising-edge clock, the only clock.
REQ-003 The ports SHALL include: rst_n  input  1  asynchronous, active-low reset.
REQ-004 The ports SHALL include: RegWrite_i  input  1  write-back enable from the MEM/WB register.
REQ-005 The ports SHALL include: MemtoReg_i  input  1  write-data select (1 = memory data, 0 = ALU result).
REQ-006 The ports SHALL include: ALUResult_i  input  32  ALU result from MEM/WB, and MemData_i  input  32  load data from MEM/WB.
REQ-007 The ports SHALL include: RegDest_i  input  5  destination register index.
REQ-008 The ports SHALL include: RS1addr_i  input  5 and RS2addr_i  input  5, the decode-stage read indices.
REQ-009 The ports SHALL include: RS1data_o  output  32 and RS2data_o  output  32, the read data.
REQ-010 The ports SHALL include: WBData_o  output  32, the selected write-back data.
REQ-011 The ports SHALL include: WrCount_o  output  CNT_W, the count of retired register writes.

Function
REQ-012 WBData_o SHALL be combinational: MemData_i when MemtoReg_i=1, else ALUResult_i.
REQ-013 The block SHALL hold 32 registers x0..x31, each 32 bits wide.
REQ-014 An effective write SHALL be RegWrite_i=1 with RegDest_i!=0; on each rising clk edge with an effective write, register[RegDest_i] SHALL take WBData_o.
REQ-015 Writes with RegDest_i=0 SHALL be discarded; x0 SHALL always read 0.
REQ-016 Reads SHALL be combinational from the current array contents, so a written value becomes visible the cycle after the write edge.
REQ-017 RS1 and RS2 SHALL be independent; equal addresses SHALL return identical data.
REQ-018 WrCount_o SHALL increment by 1 on each clk edge with an effective write, SHALL wrap from all-ones to 0, and SHALL be unchanged by discarded writes.
REQ-019 When RegWrite_i=0, no register and not WrCount_o SHALL change, regardless of the other inputs.

Reset
REQ-020 When rst_n=0, all 32 registers and WrCount_o SHALL clear to 0 immediately, with no dependence on clk.
REQ-021 While rst_n=0, writes SHALL be ignored; RS1data_o and RS2data_o SHALL read 0, with or without the bypass.
REQ-022 A write coincident with reset assertion SHALL be lost.
REQ-023 The first write after deassertion SHALL occur on the first rising clk edge at which rst_n=1.
REQ-024 WBData_o SHALL stay purely combinational and SHALL be unaffected by reset.

Configuration
REQ-025 With macro WB_BYPASS_EN defined, when RS1addr_i or RS2addr_i equals RegDest_i, the write is effective, and rst_n=1, that read port SHALL return WBData_o in the same cycle (write-through).
REQ-026 With WB_BYPASS_EN undefined, there SHALL be no bypass, and reads SHALL return the pre-edge array value as in REQ-016.
REQ-027 In both builds, x0 SHALL never be bypassed.

Verification
REQ-028 Write-then-read: reset, then write x5=0x12345678 with MemtoReg_i=0 -> RS1addr_i=5 reads 0x12345678 the next cycle, and WrCount_o=1.
REQ-029 Memory select: MemtoReg_i=1, MemData_i=0xDEADBEEF, ALUResult_i=0x1, RegDest_i=7 -> WBData_o=0xDEADBEEF, and x7=0xDEADBEEF after the edge.
REQ-030 x0 protection: write 0xFFFFFFFF to x0 -> RS2addr_i=0 reads 0, and WrCount_o is unchanged.
REQ-031 Same-cycle hazard: write x3=0xA5A5A5A5 while RS1addr_i=3 and the old x3=0 -> RS1data_o=0xA5A5A5A5 in that cycle with WB_BYPASS_EN, and 0 without it.
REQ-032 Counter wrap: with CNT_W=4, perform 17 effective writes -> WrCount_o=1.
REQ-033 Mid-operation reset: write x9=0x55, then assert rst_n=0 between clk edges -> x9 reads 0 and WrCount_o=0 before the next edge; a RegWrite_i held during reset has no effect.
